// File: rtl/blowfish128_pkg.sv
// Shared types and helpers for the Blowfish-128 round sequencer.
//   state_t  : sequencer FSM states
//   BLOCK_W  : full block width (two halves)
//   HALF_W   : Feistel half width
//   p_index  : round -> P-array index, reversed for decryption
package blowfish128_pkg;

  localparam int BLOCK_W = 128;
  localparam int HALF_W  = 64;

  typedef enum logic [2:0] {
    IDLE, XOR_P, F_RUN, F_CLR, FIN0, FIN1, DONE
  } state_t;

  // Encryption walks P[0..N+1]; decryption walks the same array backwards.
  function automatic int unsigned p_index(input int unsigned i,
                                          input logic        dir,
                                          input int unsigned num_rounds);
    return dir ? (num_rounds + 1 - i) : i;
  endfunction

endpackage

// File: rtl/blowfish128_round_ctrl.sv
// Iterative Feistel round sequencer for the Blowfish-128 core. Drives the
// peer F-function instance and the P-array key store.
//
// Ports:
//   Clk, RstN          clock, async active-low reset
//   inValid/inReady    input block handshake (ready only in IDLE)
//   dataIn             input block {L,R}
//   Decrypt            direction, sampled at acceptance
//   outValid/outReady  result handshake
//   dataOut            result block {L,R}, held while stalled
//   pIdx / pKey        subkey index out, P[pIdx] back in the same cycle
//   fEnable/fX         F-function enable (low clears it) and input
//   fY/fValid          F-function result and its valid
//   busy               high outside IDLE
//
// Build option: BLOWFISH128_DECRYPT_EN enables the decrypt direction.
// Without it the Decrypt port is present but ignored (encrypt only).
module blowfish128_round_ctrl
  import blowfish128_pkg::*;
#(
  parameter int NUM_ROUNDS = 16,
  parameter int PIDX_W     = 5
) (
  input  logic               Clk,
  input  logic               RstN,
  input  logic               inValid,
  output logic               inReady,
  input  logic [BLOCK_W-1:0] dataIn,
  input  logic               Decrypt,
  output logic               outValid,
  input  logic               outReady,
  output logic [BLOCK_W-1:0] dataOut,
  output logic [PIDX_W-1:0]  pIdx,
  input  logic [HALF_W-1:0]  pKey,
  output logic               fEnable,
  output logic [HALF_W-1:0]  fX,
  input  logic [HALF_W-1:0]  fY,
  input  logic               fValid,
  output logic               busy
);

  state_t              state, state_nx;
  logic [HALF_W-1:0]   l_q, l_nx, r_q, r_nx;
  logic [PIDX_W-1:0]   round_q, round_nx;
  logic [PIDX_W-1:0]   pidx_q, pidx_nx;
  logic                dir_q, dir_nx, dir_in;
  logic                out_vld_q, out_vld_nx;
  logic [BLOCK_W-1:0]  dout_q, dout_nx;

`ifdef BLOWFISH128_DECRYPT_EN
  assign dir_in = Decrypt;
`else
  logic decrypt_unused;
  assign decrypt_unused = Decrypt;
  assign dir_in         = 1'b0;
`endif

  // Subkey index is only driven in the three key-consuming states and
  // otherwise holds, so the key store sees a stable address.
  always_comb begin
    pidx_nx = pidx_q;
    case (state)
      XOR_P: pidx_nx = PIDX_W'(p_index(32'(round_q), dir_q, unsigned'(NUM_ROUNDS)));
      FIN0:  pidx_nx = PIDX_W'(p_index(unsigned'(NUM_ROUNDS), dir_q, unsigned'(NUM_ROUNDS)));
      FIN1:  pidx_nx = PIDX_W'(p_index(unsigned'(NUM_ROUNDS + 1), dir_q, unsigned'(NUM_ROUNDS)));
      default: ;
    endcase
  end

  always_comb begin
    state_nx   = state;
    l_nx       = l_q;
    r_nx       = r_q;
    round_nx   = round_q;
    dir_nx     = dir_q;
    out_vld_nx = out_vld_q;
    dout_nx    = dout_q;
    case (state)
      IDLE: begin
        if (inValid) begin
          l_nx     = dataIn[BLOCK_W-1:HALF_W];
          r_nx     = dataIn[HALF_W-1:0];
          round_nx = '0;
          dir_nx   = dir_in;
          state_nx = XOR_P;
        end
      end
      XOR_P: begin
        l_nx     = l_q ^ pKey;
        state_nx = F_RUN;
      end
      F_RUN: begin
        // Round body fused with the half swap.
        if (fValid) begin
          l_nx     = r_q ^ fY;
          r_nx     = l_q;
          round_nx = round_q + 1'b1;
          state_nx = F_CLR;
        end
      end
      F_CLR: begin
        // One cycle with fEnable low flushes the F-function.
        state_nx = (round_q == PIDX_W'(NUM_ROUNDS)) ? FIN0 : XOR_P;
      end
      FIN0: begin
        // Undo the final swap and whiten the right half.
        l_nx     = r_q;
        r_nx     = l_q ^ pKey;
        state_nx = FIN1;
      end
      FIN1: begin
        l_nx       = l_q ^ pKey;
        dout_nx    = {l_q ^ pKey, r_q};
        out_vld_nx = 1'b1;
        state_nx   = DONE;
      end
      DONE: begin
        if (outReady) begin
          out_vld_nx = 1'b0;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state     <= IDLE;
      l_q       <= '0;
      r_q       <= '0;
      round_q   <= '0;
      dir_q     <= 1'b0;
      pidx_q    <= '0;
      out_vld_q <= 1'b0;
      dout_q    <= '0;
    end else begin
      state     <= state_nx;
      l_q       <= l_nx;
      r_q       <= r_nx;
      round_q   <= round_nx;
      dir_q     <= dir_nx;
      pidx_q    <= pidx_nx;
      out_vld_q <= out_vld_nx;
      dout_q    <= dout_nx;
    end
  end

  // fEnable decodes from the state register, so reset drops it immediately.
  assign inReady  = RstN && (state == IDLE);
  assign busy     = (state != IDLE);
  assign fEnable  = (state == F_RUN);
  assign fX       = l_q;
  assign pIdx     = pidx_nx;
  assign outValid = out_vld_q;
  assign dataOut  = dout_q;

endmodule

// File: tb/tb_blowfish128_round_ctrl.sv
module tb_blowfish128_round_ctrl;

  logic          Clk = 1'b0;
  logic          RstN = 1'b0;
  logic          inValid = 1'b0;
  logic          Decrypt = 1'b0;
  logic          outReady = 1'b1;
  logic [127:0]  dataIn = '0;
  logic          inReady, outValid, fEnable, busy, fValid;
  logic [127:0]  dataOut;
  logic [4:0]    pIdx;
  logic [63:0]   pKey, fX, fY;

  int            n_vec = 0;
  int            n_err = 0;
  logic [127:0]  exp_q[$];
  logic [127:0]  last_out = '0;
  bit            pmode = 1'b0, fmode = 1'b0, spur = 1'b0;
  logic [1:0]    fcnt;

  always #5 Clk = ~Clk;

  blowfish128_round_ctrl dut (
    .Clk(Clk), .RstN(RstN), .inValid(inValid), .inReady(inReady),
    .dataIn(dataIn), .Decrypt(Decrypt), .outValid(outValid),
    .outReady(outReady), .dataOut(dataOut), .pIdx(pIdx), .pKey(pKey),
    .fEnable(fEnable), .fX(fX), .fY(fY), .fValid(fValid), .busy(busy)
  );

  // Bench-side F-function and key store.
  function automatic logic [63:0] mix(input logic [63:0] x);
    logic [63:0] t;
    t = x * 64'h9E3779B97F4A7C15;
    return t ^ (t >> 29) ^ 64'h0F1E2D3C4B5A6978;
  endfunction

  function automatic logic [63:0] fm(input logic [63:0] x, input bit m);
    return m ? mix(x) : 64'd0;
  endfunction

  function automatic logic [63:0] pk(input logic [4:0] i, input bit m);
    return m ? {32'h243F6A88 ^ {27'd0, i}, 32'h85A308D3 + {27'd0, i} * 32'h01000193} : 64'd0;
  endfunction

  assign pKey   = pk(pIdx, pmode);
  assign fY     = fEnable ? fm(fX, fmode) : (spur ? 64'hBADBADBADBADBAD0 : 64'd0);
  assign fValid = fEnable ? (fcnt == 2'd2) : spur;

  // F stub answers in the third enabled cycle (Lf = 3).
  always @(posedge Clk or negedge RstN) begin
    if (!RstN)         fcnt <= 2'd0;
    else if (!fEnable) fcnt <= 2'd0;
    else               fcnt <= fcnt + 2'd1;
  end

  // Reference Blowfish-style cipher on 64-bit halves.
  function automatic logic [127:0] model(input logic [127:0] blk, input bit dir,
                                         input bit pm, input bit fmd);
    logic [63:0] l, r, t;
    int k;
    l = blk[127:64];
    r = blk[63:0];
    for (int i = 0; i < 16; i++) begin
      k = dir ? 17 - i : i;
      l = l ^ pk(5'(k), pm);
      r = r ^ fm(l, fmd);
      t = l; l = r; r = t;
    end
    t = l; l = r; r = t;
    r = r ^ pk(dir ? 5'd1 : 5'd16, pm);
    l = l ^ pk(dir ? 5'd0 : 5'd17, pm);
    return {l, r};
  endfunction

  function automatic bit eff_dir(input bit dec);
`ifdef BLOWFISH128_DECRYPT_EN
    return dec;
`else
    return 1'b0 & dec;
`endif
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge Clk) begin
    if (RstN && outValid && outReady) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got %h expected none", dataOut);
      end else begin
        check("dataOut", dataOut, exp_q.pop_front());
      end
      last_out = dataOut;
    end
  end

  task automatic run_block(input logic [127:0] blk, input bit dec, input bit push,
                           input logic [127:0] exp, input bit chk_idx, output int lat);
    int cyc, nr;
    logic pf;
    logic [4:0] seen[16];
    logic [4:0] fin;
    bit ed;
    ed  = eff_dir(dec);
    cyc = 0;
    while (!inReady && cyc < 100) begin @(posedge Clk); #1; cyc++; end
    check("in_ready_wait", 128'(inReady), 128'd1);
    if (push) exp_q.push_back(exp);
    dataIn  = blk;
    Decrypt = dec;
    inValid = 1'b1;
    @(posedge Clk); #1;
    inValid = 1'b0;
    dataIn  = ~blk;
    Decrypt = ~dec;
    cyc = 1; nr = 0; pf = 1'b0;
    while (!outValid && cyc < 2000) begin
      if (fEnable && !pf && nr < 16) begin seen[nr] = pIdx; nr++; end
      pf = fEnable;
      @(posedge Clk); #1;
      cyc++;
    end
    check("out_valid_seen", 128'(outValid), 128'd1);
    fin = pIdx;
    lat = cyc;
    if (chk_idx) begin
      check("round_count", 128'(nr), 128'd16);
      for (int i = 0; i < 16; i++) check("pidx_round", 128'(seen[i]), 128'(ed ? 17 - i : i));
      check("pidx_final", 128'(fin), 128'(ed ? 0 : 17));
    end
    if (outReady) begin @(posedge Clk); #1; end
  endtask

  initial begin
    int lat, nr, cyc;
    logic pf;
    logic [127:0] ct, hold, blk;

    // 1. Reset
    repeat (3) @(posedge Clk);
    @(negedge Clk) RstN = 1'b1;
    #1;
    check("rst_in_ready", 128'(inReady), 128'd1);
    check("rst_out_valid", 128'(outValid), 128'd0);
    check("rst_f_enable", 128'(fEnable), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_data_out", dataOut, 128'd0);
    check("rst_pidx", 128'(pIdx), 128'd0);
    @(posedge Clk); #1;

    // 2. Structural: F=0, P=0 leaves the halves swapped
    run_block({64'h0123456789ABCDEF, 64'hFEDCBA9876543210}, 1'b0, 1'b1,
              {64'hFEDCBA9876543210, 64'h0123456789ABCDEF}, 1'b1, lat);
    check("latency_struct", 128'(lat), 128'd83);

    // 3. Round trip with keyed F
    pmode = 1'b1; fmode = 1'b1;
    run_block(128'd0, 1'b0, 1'b1, model(128'd0, 1'b0, 1'b1, 1'b1), 1'b1, lat);
    ct = last_out;
`ifdef BLOWFISH128_DECRYPT_EN
    run_block(ct, 1'b1, 1'b1, 128'd0, 1'b1, lat);
`else
    run_block(ct, 1'b1, 1'b1, model(ct, 1'b0, 1'b1, 1'b1), 1'b1, lat);
`endif

    // 4. Backpressure
    blk = 128'h00112233445566778899AABBCCDDEEFF;
    outReady = 1'b0;
    run_block(blk, 1'b0, 1'b1, model(blk, 1'b0, 1'b1, 1'b1), 1'b0, lat);
    hold = dataOut;
    repeat (10) begin
      @(posedge Clk); #1;
      check("bp_out_valid", 128'(outValid), 128'd1);
      check("bp_data_stable", dataOut, hold);
      check("bp_in_ready", 128'(inReady), 128'd0);
    end
    outReady = 1'b1;
    @(posedge Clk); #1;
    check("bp_out_valid_drop", 128'(outValid), 128'd0);
    check("bp_in_ready_rise", 128'(inReady), 128'd1);

    // 5. Reset during F_RUN of round 7
    dataIn = 128'hCAFEF00DDEADBEEF0123456789ABCDEF;
    inValid = 1'b1;
    @(posedge Clk); #1;
    inValid = 1'b0;
    nr = 0; pf = 1'b0; cyc = 0;
    while (nr < 8 && cyc < 2000) begin
      @(posedge Clk); #1;
      cyc++;
      if (fEnable && !pf) nr++;
      pf = fEnable;
    end
    check("abort_round7_reached", 128'(nr), 128'd8);
    #2 RstN = 1'b0;
    #1;
    check("abort_f_enable", 128'(fEnable), 128'd0);
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_out_valid", 128'(outValid), 128'd0);
    @(negedge Clk) RstN = 1'b1;
    #1;
    check("abort_in_ready", 128'(inReady), 128'd1);
    repeat (5) @(posedge Clk);
    #1;
    check("abort_no_output", 128'(outValid), 128'd0);
    blk = 128'h0F0E0D0C0B0A09080706050403020100;
    run_block(blk, 1'b0, 1'b1, model(blk, 1'b0, 1'b1, 1'b1), 1'b0, lat);

    // 6. Spurious fValid/fY outside F_RUN
    spur = 1'b1;
    blk = 128'h13579BDF2468ACE0FEDCBA9876543210;
    run_block(blk, 1'b0, 1'b1, model(blk, 1'b0, 1'b1, 1'b1), 1'b1, lat);
    check("latency_spurious", 128'(lat), 128'd83);
    spur = 1'b0;

    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin @(posedge Clk); cyc++; end
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
